seg7_scan_driver: RTL and testbench

Time-multiplexed 4-digit common-anode seven-segment driver. It sits directly downstream of the 1 Hz hex counter, which drives one nibble of `value`. The block latches a coherent 16-bit snapshot once per scan frame, then cycles the four anodes at a fixed refresh rate. It decodes each nibble to hex segment patterns, with per-digit blanking and decimal-point control.

---
 rtl/seg7_pkg.sv | 22 ++
 rtl/hex_to_seg7.sv | 11 +
 rtl/seg7_scan_driver.sv | 160 ++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for the multiplexed seven-segment driver.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

  typedef logic [1:0] digit_idx_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  localparam logic [6:0] HEX_SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Active-low one-hot anode pattern selecting a single digit.
  function automatic logic [3:0] an_select(input digit_idx_t idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low hex segment pattern decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode scan driver: frame-coherent input snapshot,
// fixed-rate digit rotation, optional anti-ghosting guard per slot.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic [3:0]  blank,
  input  logic [3:0]  dp_in,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYCLES);

  logic [CNT_W-1:0] prescaler_r;
  logic [CNT_W-1:0] guard_cnt_r;
  logic             tick_s;
  logic             capture_s;
  digit_idx_t       idx_r;
  digit_idx_t       nxt_idx_s;

  logic [15:0]      snap_value_r;
  logic [3:0]       snap_blank_r;
  logic [3:0]       snap_dp_r;

  logic [15:0]      sel_value_s;
  logic [3:0]       sel_blank_s;
  logic [3:0]       sel_dp_s;
  logic [3:0]       nibble_s;
  logic [6:0]       dec_seg_s;
  logic [6:0]       slot_seg_s;
  logic             slot_dp_s;

  logic [6:0]       seg_r;
  logic             dp_r;
  logic [3:0]       an_r;

  assign tick_s    = (prescaler_r == LAST_CNT);
  assign nxt_idx_s = digit_idx_t'(idx_r + 2'd1);
  assign capture_s = tick_s && (idx_r == 2'd3);

  // Slot prescaler: wraps every REFRESH_DIV cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler_r <= CNT_ZERO;
    end else if (tick_s) begin
      prescaler_r <= CNT_ZERO;
    end else begin
      prescaler_r <= prescaler_r + CNT_ONE;
    end
  end

  // Digit index rotation 0,1,2,3,0...
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_r <= 2'd3;
    end else if (tick_s) begin
      idx_r <= nxt_idx_s;
    end else begin
      idx_r <= idx_r;
    end
  end

  // Frame snapshot, taken only on the edge that starts digit 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_value_r <= 16'h0000;
      snap_blank_r <= 4'h0;
      snap_dp_r    <= 4'h0;
    end else if (capture_s) begin
      snap_value_r <= value;
      snap_blank_r <= blank;
      snap_dp_r    <= dp_in;
    end else begin
      snap_value_r <= snap_value_r;
      snap_blank_r <= snap_blank_r;
      snap_dp_r    <= snap_dp_r;
    end
  end

  // Digit 0 must show the value being captured on this very edge, so
  // bypass the snapshot registers while capturing.
  always_comb begin
    sel_value_s = snap_value_r;
    sel_blank_s = snap_blank_r;
    sel_dp_s    = snap_dp_r;
    if (capture_s) begin
      sel_value_s = value;
      sel_blank_s = blank;
      sel_dp_s    = dp_in;
    end else begin
      sel_value_s = snap_value_r;
      sel_blank_s = snap_blank_r;
      sel_dp_s    = snap_dp_r;
    end
  end

  // Nibble select and blank/dp resolution for the upcoming slot.
  always_comb begin
    nibble_s = 4'h0;
    case (nxt_idx_s)
      2'd0:    nibble_s = sel_value_s[3:0];
      2'd1:    nibble_s = sel_value_s[7:4];
      2'd2:    nibble_s = sel_value_s[11:8];
      2'd3:    nibble_s = sel_value_s[15:12];
      default: nibble_s = 4'h0;
    endcase
    if (sel_blank_s[nxt_idx_s]) begin
      slot_seg_s = SEG_BLANK;
    end else begin
      slot_seg_s = dec_seg_s;
    end
    slot_dp_s = ~sel_dp_s[nxt_idx_s];
  end

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (nibble_s),
    .seg    (dec_seg_s)
  );

  // Output registers; anodes stay dark for the guard window of each slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_r       <= SEG_BLANK;
      dp_r        <= 1'b1;
      an_r        <= AN_OFF;
      guard_cnt_r <= CNT_ZERO;
    end else if (tick_s) begin
      seg_r       <= slot_seg_s;
      dp_r        <= slot_dp_s;
      an_r        <= (GUARD_CYCLES == 0) ? an_select(nxt_idx_s) : AN_OFF;
      guard_cnt_r <= GUARD_LOAD;
    end else if (guard_cnt_r != CNT_ZERO) begin
      seg_r       <= seg_r;
      dp_r        <= dp_r;
      an_r        <= (guard_cnt_r == CNT_ONE) ? an_select(idx_r) : an_r;
      guard_cnt_r <= guard_cnt_r - CNT_ONE;
    end else begin
      seg_r       <= seg_r;
      dp_r        <= dp_r;
      an_r        <= an_r;
      guard_cnt_r <= guard_cnt_r;
    end
  end

  assign seg = seg_r;
  assign dp  = dp_r;
  assign an  = an_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: two instances (no guard / guard) checked each
// cycle against a timeline model driven by recorded input history.
module tb_seg7_scan_driver;

  localparam int RD_A = 4;
  localparam int G_A  = 0;
  localparam int RD_B = 6;
  localparam int G_B  = 2;
  localparam int HIST = 8192;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = 16'h0000;
  logic [3:0]  blank = 4'h0;
  logic [3:0]  dp_in = 4'h0;
  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b;
  logic [3:0]  an_a, an_b;

  int errors = 0;
  int checks = 0;
  int k = 0;
  logic [15:0] hist_v [HIST];
  logic [3:0]  hist_b [HIST];
  logic [3:0]  hist_p [HIST];

  seg7_scan_driver #(.REFRESH_DIV(RD_A), .GUARD_CYCLES(G_A)) dut_a (
    .clk(clk), .reset(reset), .value(value), .blank(blank), .dp_in(dp_in),
    .seg(seg_a), .dp(dp_a), .an(an_a)
  );

  seg7_scan_driver #(.REFRESH_DIV(RD_B), .GUARD_CYCLES(G_B)) dut_b (
    .clk(clk), .reset(reset), .value(value), .blank(blank), .dp_in(dp_in),
    .seg(seg_b), .dp(dp_b), .an(an_b)
  );

  always #5 clk = ~clk;

  // Edges since reset release, plus the inputs seen at each of those edges.
  always @(posedge clk) begin
    if (reset) begin
      k <= 0;
    end else begin
      k <= k + 1;
      if (k + 1 < HIST) begin
        hist_v[k+1] <= value;
        hist_b[k+1] <= blank;
        hist_p[k+1] <= dp_in;
      end
    end
  end

  function automatic logic [6:0] ref_hex(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  4'hF: return 7'b0001110;
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected {an,seg,dp} after edge kk: slot j begins at edge (j+1)*rd and
  // shows digit j%4 from the inputs seen at the edge that began its frame.
  function automatic logic [11:0] ref_out(input int kk, input int rd, input int g);
    int slot, m, d, c;
    logic [15:0] v;
    logic [3:0] b, p, an_e;
    logic [6:0] s_e;
    if (kk < rd) return 12'hFFF;
    slot = kk / rd - 1;
    m    = kk - (slot + 1) * rd;
    d    = slot % 4;
    c    = (slot - d + 1) * rd;
    v = hist_v[c];
    b = hist_b[c];
    p = hist_p[c];
    s_e = b[d] ? 7'b1111111 : ref_hex(v[4*d +: 4]);
    an_e = 4'b1111;
    if (m >= g) an_e[d] = 1'b0;
    return {an_e, s_e, ~p[d]};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({an_a, seg_a, dp_a} !== 12'hFFF) begin
      errors++; $display("FAIL reset_a: got %h expected fff", {an_a, seg_a, dp_a});
    end
    checks++;
    if ({an_b, seg_b, dp_b} !== 12'hFFF) begin
      errors++; $display("FAIL reset_b: got %h expected fff", {an_b, seg_b, dp_b});
    end
  endtask

  task automatic test_basic();
    logic [11:0] ea, eb;
    value = 16'h1234; blank = 4'h0; dp_in = 4'h0;
    reset = 1'b0;
    for (int i = 1; i <= 5 * RD_A; i++) begin
      @(negedge clk);
      ea = ref_out(k, RD_A, G_A); eb = ref_out(k, RD_B, G_B);
      checks += 2;
      if ({an_a, seg_a, dp_a} !== ea) begin
        errors++; $display("FAIL basic_a k=%0d: got %h expected %h", k, {an_a, seg_a, dp_a}, ea);
      end
      if ({an_b, seg_b, dp_b} !== eb) begin
        errors++; $display("FAIL basic_b k=%0d: got %h expected %h", k, {an_b, seg_b, dp_b}, eb);
      end
      if (i == RD_A) begin
        checks++;
        if (an_a !== 4'b1110 || seg_a !== 7'b0011001) begin
          errors++; $display("FAIL first_digit: got an=%b seg=%b expected an=1110 seg=0011001", an_a, seg_a);
        end
      end
    end
  endtask

  task automatic test_coherence();
    logic [11:0] ea, eb;
    logic [6:0] lit;
    for (int i = 0; i < 5 + 28; i++) begin
      @(negedge clk);
      ea = ref_out(k, RD_A, G_A); eb = ref_out(k, RD_B, G_B);
      checks += 2;
      if ({an_a, seg_a, dp_a} !== ea) begin
        errors++; $display("FAIL coherence_a k=%0d: got %h expected %h", k, {an_a, seg_a, dp_a}, ea);
      end
      if ({an_b, seg_b, dp_b} !== eb) begin
        errors++; $display("FAIL coherence_b k=%0d: got %h expected %h", k, {an_b, seg_b, dp_b}, eb);
      end
      if (k == 28 || k == 32 || k == 36 || k == 40) begin
        case (k)
          28: lit = 7'b0100100;
          32: lit = 7'b1111001;
          36: lit = 7'b0100001;
          default: lit = 7'b1000110;
        endcase
        checks++;
        if (seg_a !== lit) begin
          errors++; $display("FAIL coherence_lit k=%0d: got %b expected %b", k, seg_a, lit);
        end
      end
      if (k == 25) value = 16'hABCD;
    end
  endtask

  task automatic test_blank_dp();
    logic [11:0] ea, eb;
    int k0;
    blank = 4'b1000; dp_in = 4'b0001; value = 16'h00F0;
    k0 = k;
    for (int i = 0; i < 10 * RD_A; i++) begin
      @(negedge clk);
      ea = ref_out(k, RD_A, G_A); eb = ref_out(k, RD_B, G_B);
      checks += 2;
      if ({an_a, seg_a, dp_a} !== ea) begin
        errors++; $display("FAIL blank_a k=%0d: got %h expected %h", k, {an_a, seg_a, dp_a}, ea);
      end
      if ({an_b, seg_b, dp_b} !== eb) begin
        errors++; $display("FAIL blank_b k=%0d: got %h expected %h", k, {an_b, seg_b, dp_b}, eb);
      end
      if (k >= k0 + 4 * RD_A) begin
        checks++;
        if (an_a == 4'b1110 && (seg_a !== 7'b1000000 || dp_a !== 1'b0)) begin
          errors++; $display("FAIL blank_d0: got seg=%b dp=%b expected seg=1000000 dp=0", seg_a, dp_a);
        end else if (an_a == 4'b1101 && (seg_a !== 7'b0001110 || dp_a !== 1'b1)) begin
          errors++; $display("FAIL blank_d1: got seg=%b dp=%b expected seg=0001110 dp=1", seg_a, dp_a);
        end else if (an_a == 4'b0111 && seg_a !== 7'b1111111) begin
          errors++; $display("FAIL blank_d3: got seg=%b expected 1111111", seg_a);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] ea, eb;
    bit found;
    int na, nb;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      ea = ref_out(k, RD_A, G_A);
      checks++;
      if ({an_a, seg_a, dp_a} !== ea) begin
        errors++; $display("FAIL pre_reset_a k=%0d: got %h expected %h", k, {an_a, seg_a, dp_a}, ea);
      end
      if (an_a == 4'b1011) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL reset_mid_wait: got no idx2 slot expected one within 64 cycles");
    end
    reset = 1'b1;
    @(negedge clk);
    checks += 2;
    if ({an_a, seg_a, dp_a} !== 12'hFFF) begin
      errors++; $display("FAIL reset_mid_a: got %h expected fff", {an_a, seg_a, dp_a});
    end
    if ({an_b, seg_b, dp_b} !== 12'hFFF) begin
      errors++; $display("FAIL reset_mid_b: got %h expected fff", {an_b, seg_b, dp_b});
    end
    reset = 1'b0;
    na = 0; nb = 0;
    for (int n = 1; n <= 2 * (RD_B + G_B); n++) begin
      @(negedge clk);
      ea = ref_out(k, RD_A, G_A); eb = ref_out(k, RD_B, G_B);
      checks += 2;
      if ({an_a, seg_a, dp_a} !== ea) begin
        errors++; $display("FAIL post_reset_a k=%0d: got %h expected %h", k, {an_a, seg_a, dp_a}, ea);
      end
      if ({an_b, seg_b, dp_b} !== eb) begin
        errors++; $display("FAIL post_reset_b k=%0d: got %h expected %h", k, {an_b, seg_b, dp_b}, eb);
      end
      if (an_a !== 4'b1111 && na == 0) na = n;
      if (an_b !== 4'b1111 && nb == 0) nb = n;
    end
    checks += 2;
    if (na != RD_A) begin
      errors++; $display("FAIL relight_a: got %0d cycles expected %0d", na, RD_A);
    end
    if (nb != RD_B + G_B) begin
      errors++; $display("FAIL relight_b: got %0d cycles expected %0d", nb, RD_B + G_B);
    end
  endtask

  task automatic test_random(input string name, input int cycles, input bit sweep);
    logic [11:0] ea, eb;
    for (int i = 0; i < cycles; i++) begin
      if (sweep) begin
        if (i % (4 * RD_B) == 0) value = {16'($urandom) & 16'hFFF0} | 16'(i / (4 * RD_B));
      end else if ($urandom_range(0, 6) == 0) begin
        value = 16'($urandom); blank = 4'($urandom); dp_in = 4'($urandom);
      end
      @(negedge clk);
      ea = ref_out(k, RD_A, G_A); eb = ref_out(k, RD_B, G_B);
      checks += 3;
      if ({an_a, seg_a, dp_a} !== ea) begin
        errors++; $display("FAIL %s_a k=%0d: got %h expected %h", name, k, {an_a, seg_a, dp_a}, ea);
      end
      if ({an_b, seg_b, dp_b} !== eb) begin
        errors++; $display("FAIL %s_b k=%0d: got %h expected %h", name, k, {an_b, seg_b, dp_b}, eb);
      end
      if ($countones(~an_a) > 1 || $countones(~an_b) > 1) begin
        errors++; $display("FAIL %s_onehot: got an_a=%b an_b=%b expected at most one low", name, an_a, an_b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_coherence();
    test_blank_dp();
    test_reset_mid();
    test_random("guard", 6 * 4 * RD_B, 1'b0);
    blank = 4'h0; dp_in = 4'b0101;
    test_random("sweep", 16 * 4 * RD_B, 1'b1);
    test_random("random", 400, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
